// File: rtl/slc3_pkg.sv
// Shared SLC-3 memory-path types and constants.
// Holds the sequencer state encoding and the width and latency limits.
package slc3_pkg;

  localparam int SLC3_DATA_WIDTH = 16;
  localparam int SLC3_ADDR_WIDTH = 16;
  localparam int MEM_LAT_MAX     = 15;
  localparam int LAT_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_lat_counter.sv
// Loadable 4-bit down-counter with zero flag, async active-low reset.
// Ports: clk, reset, i_load/i_load_val load, i_dec decrement, o_zero flag.
module lat_counter
  import slc3_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [LAT_CNT_W-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_zero
);

  logic [LAT_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: valid/ready request in, valid/ready response out.
// Ports: req_* request, rsp_* response, mem_* memory port, busy status.
module mem_access_ctrl
  import slc3_pkg::*;
#(
  parameter int DATA_WIDTH    = SLC3_DATA_WIDTH,
  parameter int ADDR_WIDTH    = SLC3_ADDR_WIDTH,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_was_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_mem_ena,
  output logic                  mem_wr_ena,
  output logic                  busy
);

  generate
    if ((READ_LATENCY < 1) || (READ_LATENCY > MEM_LAT_MAX) ||
        (WRITE_LATENCY < 1) || (WRITE_LATENCY > MEM_LAT_MAX)) begin : g_bad_lat
      $error("mem_access_ctrl: latency out of range 1..15");
    end
  endgenerate

  localparam logic [LAT_CNT_W-1:0] RD_LOAD = LAT_CNT_W'(READ_LATENCY - 1);
  localparam logic [LAT_CNT_W-1:0] WR_LOAD = LAT_CNT_W'(WRITE_LATENCY - 1);

  mem_state_t r_state;
  mem_state_t w_state_nxt;

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_was_write;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_ena;
  logic                  r_mem_wr;
  logic                  r_we;

  logic                  w_acc;
  logic                  w_rsp_hs;
  logic                  w_cnt_zero;
  logic                  w_load;
  logic [LAT_CNT_W-1:0]  w_load_val;
  logic                  w_dec;
  logic                  w_cap_rd;
  logic                  w_ent_resp;
  logic                  w_ena_d;
  logic                  w_wr_d;

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_acc     = req_valid & req_ready;
  assign w_rsp_hs  = r_rsp_valid & rsp_ready;

  lat_counter u_lat (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  // State register plus the registered outputs it feeds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_was_write <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_addr      <= '0;
      r_mem_ena       <= 1'b0;
      r_mem_wr        <= 1'b0;
      r_we            <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (w_state_nxt == RESP);
      r_mem_ena   <= w_ena_d;
      r_mem_wr    <= w_wr_d;
      if (w_acc) begin
        r_mem_addr  <= req_addr;
        r_mem_wdata <= req_wdata;
        r_we        <= req_we;
      end
      if (w_cap_rd) begin
        r_rsp_rdata <= mem_rdata;
      end
      if (w_ent_resp) begin
        r_rsp_was_write <= r_we;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:        if (w_acc) w_state_nxt = req_we ? WRITE : READ;
      READ, WRITE: if (w_cnt_zero) w_state_nxt = RESP;
      RESP:        if (w_rsp_hs) w_state_nxt = IDLE;
      default:     w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered strobes and counter controls.
  always_comb begin
    w_load     = w_acc;
    w_load_val = req_we ? WR_LOAD : RD_LOAD;
    w_dec      = (r_state == READ) || (r_state == WRITE);
    w_cap_rd   = (r_state == READ) && w_cnt_zero;
    w_ent_resp = (r_state != RESP) && (w_state_nxt == RESP);
    w_ena_d    = (w_state_nxt == READ) || (w_state_nxt == WRITE);
    w_wr_d     = (w_state_nxt == WRITE);
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_was_write = r_rsp_was_write;
  assign mem_wdata     = r_mem_wdata;
  assign mem_addr      = r_mem_addr;
  assign mem_mem_ena   = r_mem_ena;
  assign mem_wr_ena    = r_mem_wr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural memory.
// Random and directed accesses checked against a reference memory image.
module tb_mem_access_ctrl;

  localparam int RL = 2;
  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_was_write;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem_wdata;
  logic [15:0] mem_addr;
  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem_arr [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_rdata = '0;
  int          rd_n = 0;

  mem_access_ctrl #(
    .DATA_WIDTH    (16),
    .ADDR_WIDTH    (16),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_was_write (rsp_was_write),
    .mem_rdata     (mem_rdata),
    .mem_wdata     (mem_wdata),
    .mem_addr      (mem_addr),
    .mem_mem_ena   (mem_mem_ena),
    .mem_wr_ena    (mem_wr_ena),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Memory: read data is only valid in the RL-th enabled cycle; junk otherwise.
  always @(negedge clk) begin
    if (mem_mem_ena && !mem_wr_ena) begin
      rd_n = rd_n + 1;
      mem_rdata = (rd_n == RL) ? mem_arr[mem_addr[7:0]] : 16'($urandom);
    end else begin
      rd_n = 0;
      mem_rdata = 16'($urandom);
    end
    if (mem_mem_ena && mem_wr_ena) mem_arr[mem_addr[7:0]] = mem_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_rdata, rsp_was_write, mem_addr, mem_wdata,
         mem_mem_ena, mem_wr_ena, busy} !== 53'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b rd=%h ww=%b a=%h wd=%h e=%b w=%b b=%b want all 0",
               rsp_valid, rsp_rdata, rsp_was_write, mem_addr, mem_wdata,
               mem_mem_ena, mem_wr_ena, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic do_access(input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, input int hold);
    int cyc, ena_n, wr_n, bad, lat, exp_lat;
    exp_lat = we ? WL + 1 : RL + 1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = addr ^ 16'h00C0;
    req_wdata = ~wd;
    req_we    = ~we;
    cyc = 1; ena_n = 0; wr_n = 0; bad = 0; lat = 0;
    while (cyc <= 40) begin
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (mem_mem_ena) begin
        ena_n++;
        if (mem_addr !== addr) bad++;
        if (we && (mem_wdata !== wd)) bad++;
      end
      if (mem_wr_ena) wr_n++;
      if (req_ready || !busy) bad++;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL rsp_latency: got %0d want %0d (we=%b addr=%h)", lat, exp_lat, we, addr);
    end
    n_tests++;
    if ({ena_n, wr_n} != {exp_lat - 1, we ? WL : 0}) begin
      n_fail++;
      $display("FAIL enable_cycles: got ena=%0d wr=%0d want ena=%0d wr=%0d",
               ena_n, wr_n, exp_lat - 1, we ? WL : 0);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL access_stable: got %0d bad cycles want 0 (addr=%h)", bad, addr);
    end
    if (we) ref_mem[addr[7:0]] = wd;
    else exp_rdata = ref_mem[addr[7:0]];
    n_tests++;
    if ({mem_mem_ena, mem_wr_ena, rsp_rdata, rsp_was_write} !== {2'b00, exp_rdata, we}) begin
      n_fail++;
      $display("FAIL rsp_data: got e=%b w=%b rd=%h ww=%b want e=0 w=0 rd=%h ww=%b",
               mem_mem_ena, mem_wr_ena, rsp_rdata, rsp_was_write, exp_rdata, we);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      n_tests++;
      if ({rsp_valid, rsp_rdata, rsp_was_write, busy, req_ready} !==
          {1'b1, exp_rdata, we, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure: got v=%b rd=%h ww=%b b=%b rr=%b want v=1 rd=%h ww=%b b=1 rr=0",
                 rsp_valid, rsp_rdata, rsp_was_write, busy, req_ready, exp_rdata, we);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    n_tests++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rsp_done: got v=%b b=%b rr=%b want v=0 b=0 rr=1",
               rsp_valid, busy, req_ready);
    end
  endtask

  task automatic test_directed();
    do_access(1'b0, 16'h0010, 16'h0000, 0);
    do_access(1'b1, 16'h3000, 16'h1234, 0);
    do_access(1'b0, 16'h3000, 16'h0000, 1);
    ref_mem[8'h05] = 16'h00A5;
    mem_arr[8'h05] = 16'h00A5;
    do_access(1'b0, 16'h0005, 16'h0000, 4);
    do_access(1'b0, 16'h0040, 16'h0000, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                16'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int n_acc, cyc, bad;
    logic pend;
    logic [15:0] rd_seen, wd;
    wd = 16'($urandom);
    n_acc = 0; cyc = 0; bad = 0; rd_seen = 16'hxxxx;
    acc[0] = 0; acc[1] = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0001;
    rsp_ready = 1'b1;
    while (n_acc < 2 && cyc < 40) begin
      pend = req_valid && req_ready;
      if (mem_mem_ena && rsp_valid) bad++;
      if (rsp_valid && !rsp_was_write) rd_seen = rsp_rdata;
      @(negedge clk);
      cyc++;
      if (pend) begin
        acc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          req_we    = 1'b1;
          req_addr  = 16'h0002;
          req_wdata = wd;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    n_tests++;
    if ((n_acc != 2) || (acc[1] - acc[0] != RL + 2)) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d accepts spacing %0d want 2 spacing %0d",
               n_acc, acc[1] - acc[0], RL + 2);
    end
    n_tests++;
    if (rd_seen !== ref_mem[8'h01]) begin
      n_fail++;
      $display("FAIL b2b_read: got %h want %h", rd_seen, ref_mem[8'h01]);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      if (mem_mem_ena && rsp_valid) bad++;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if ((rsp_valid !== 1'b1) || (rsp_was_write !== 1'b1) || (bad != 0)) begin
      n_fail++;
      $display("FAIL b2b_write: got v=%b ww=%b overlap=%0d want v=1 ww=1 overlap=0",
               rsp_valid, rsp_was_write, bad);
    end
    ref_mem[8'h02] = wd;
    exp_rdata = ref_mem[8'h01];
    @(negedge clk);
    rsp_ready = 1'b0;
    do_access(1'b0, 16'h0002, 16'h0000, 0);
  endtask

  task automatic test_reset_mid_read();
    int bad;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0040;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_mem_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_read_ena: got %b want 1", mem_mem_ena);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({mem_mem_ena, mem_wr_ena, rsp_valid, busy, mem_addr} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got e=%b w=%b v=%b b=%b a=%h want all 0",
               mem_mem_ena, mem_wr_ena, rsp_valid, busy, mem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_rdata = '0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready || mem_mem_ena) bad++;
    end
    rsp_ready = 1'b0;
    n_tests++;
    if ((bad != 0) || (rsp_rdata !== 16'h0000)) begin
      n_fail++;
      $display("FAIL after_abort: got bad=%0d rd=%h want bad=0 rd=0000", bad, rsp_rdata);
    end
    do_access(1'b0, 16'h0040, 16'h0000, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Parametrised memory-access sequencer between the SLC-3 control FSM / MAR-MDR datapath and the on-chip memory port.
- Replaces fixed single-cycle mem_mem_ena/mem_wr_ena strobing with a valid/ready request and response handshake.
- Supports configurable data width, address width, and independent read and write latencies.
- Control FSM issues a request, then stalls until the response handshake completes.

Parameters:
- DATA_WIDTH, 16, width of mem_rdata, mem_wdata, req_wdata and rsp_rdata.
- ADDR_WIDTH, 16, width of req_addr and mem_addr.
- READ_LATENCY, 1, cycles from mem_mem_ena rising to mem_rdata valid; legal range 1..15.
- WRITE_LATENCY, 1, cycles mem_wr_ena is held per write; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  access address (from MAR).
- req_wdata  in  DATA_WIDTH  write data (from MDR).
- rsp_valid  out  1  access complete; rsp_rdata valid for reads.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  captured read data.
- rsp_was_write  out  1  response belongs to a write.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_mem_ena  out  1  memory enable.
- mem_wr_ena  out  1  memory write enable.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE; latency counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_was_write = 0.
  - mem_addr = 0, mem_wdata = 0, mem_mem_ena = 0, mem_wr_ena = 0.
  - busy = 0; req_ready = 1 once reset is released.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - Handshake at edge E0 (req_valid & req_ready): register addr, wdata and we.
  - Next state is WRITE if we = 1, else READ.
  - Load the counter with LATENCY-1.
- READ:
  - mem_mem_ena = 1, mem_wr_ena = 0.
  - mem_addr is held stable for the whole state.
  - Counter decrements each cycle.
  - On the edge where counter = 0 (edge E0+READ_LATENCY), capture mem_rdata into rsp_rdata and go to RESP.
- WRITE:
  - mem_mem_ena = 1 and mem_wr_ena = 1 for exactly WRITE_LATENCY cycles.
  - mem_addr and mem_wdata are held stable.
  - rsp_rdata is unchanged.
  - Go to RESP on the same counter rule as READ.
- RESP:
  - rsp_valid = 1; rsp_was_write reflects the access type.
  - mem_mem_ena = 0, mem_wr_ena = 0.
  - rsp_rdata and rsp_was_write stay stable while rsp_ready = 0 (no timeout).
  - rsp_valid & rsp_ready leads to IDLE on the next edge.
- Latency:
  - Request accepted at E0 gives rsp_valid high in the cycle after E0+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
  - Back-to-back overlap is not supported; req_ready is low in READ/WRITE/RESP.
- Request signals are ignored while req_ready = 0; changing req_* mid-access has no effect.
- Simultaneous rsp_ready and new req_valid in RESP: only the response completes. The request is taken no earlier than the next cycle (IDLE).
- Reset asserted mid-access aborts immediately. Memory enables drop asynchronously and no response is produced.
- Counter width is 4 bits. Out-of-range latency parameters cause an elaboration error via generate-time check.
- All outputs are registered except req_ready and busy, which decode state.

Decomposition:
- Shared package slc3_pkg:
  - mem_state_t enum {IDLE, READ, WRITE, RESP}.
  - Constants SLC3_DATA_WIDTH = 16 and SLC3_ADDR_WIDTH = 16.
  - Constant MEM_LAT_MAX = 15.
- One natural sub-module: lat_counter (loadable 4-bit down-counter with zero flag, async active-low reset).
- The FSM and capture registers stay in mem_access_ctrl.

Test Plan:
- Read, READ_LATENCY = 1: req addr 0x0010 at E0, memory returns 0xBEEF → mem_mem_ena high exactly 1 cycle, rsp_valid in cycle after E1, rsp_rdata = 0xBEEF, rsp_was_write = 0.
- Write, WRITE_LATENCY = 3: addr 0x3000, data 0x1234 → mem_wr_ena high 3 consecutive cycles with mem_addr = 0x3000 and mem_wdata = 0x1234 stable, then rsp_valid with rsp_was_write = 1.
- Backpressure: read 0x0005 returning 0x00A5, rsp_ready held low 4 cycles → rsp_valid and rsp_rdata = 0x00A5 stable for 4 cycles, req_ready low, busy high; IDLE one cycle after rsp_ready.
- Back-to-back: req_valid held high with read 0x0001 then write 0x0002, READ_LATENCY = 2 → second acceptance exactly 4 cycles after the first, with no overlapping memory enables.
- Reset mid-READ, READ_LATENCY = 4: reset pulled low in the 2nd access cycle → mem_mem_ena = 0 immediately, rsp_valid never asserts, req_ready = 1 after release.
- Ignored input: req_addr changed from 0x0040 to 0x0080 during READ → mem_addr stays 0x0040 for the whole access.
